// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART axis frame scheduler: FSM states,
// ASCII codes of the frame characters and the decimal weight table.
package uart_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SNAP,
    ST_TAG,
    ST_SIGN,
    ST_CONV,
    ST_DIGIT,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_DONE
  } state_e;

  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_Y     = 8'h59;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int FRAME_LEN  = 25;
  localparam int NUM_DIGITS = 5;

  // Entry k is the weight of digit k, most significant digit first.
  localparam logic [4:0][14:0] POW10 = {15'd1, 15'd10, 15'd100, 15'd1000, 15'd10000};

  function automatic logic [14:0] pow10(input logic [2:0] k);
    case (k)
      3'd0:    return POW10[0];
      3'd1:    return POW10[1];
      3'd2:    return POW10[2];
      3'd3:    return POW10[3];
      default: return POW10[4];
    endcase
  endfunction

endpackage

// File: rtl/dec_digit_extractor.sv
// Extracts one decimal digit from a magnitude by repeated subtraction of the
// digit weight, one subtraction per cycle; done_o flags digit/remainder ready.
module dec_digit_extractor
  import uart_sched_pkg::*;
#(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] mag_i,
  input  logic [2:0]   idx_i,
  output logic [3:0]   digit_o,
  output logic [W-1:0] rem_o,
  output logic         done_o
);

  logic [W-1:0] rem_q;
  logic [W-1:0] pow_s;
  logic [3:0]   digit_q;
  logic [2:0]   idx_q;
  logic         run_q;
  logic         ge_s;

  always_comb begin
    pow_s = W'(pow10(idx_q));
    ge_s  = (rem_q >= pow_s);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q   <= {W{1'b0}};
      digit_q <= 4'd0;
      idx_q   <= 3'd0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      rem_q   <= mag_i;
      digit_q <= 4'd0;
      idx_q   <= idx_i;
      run_q   <= 1'b1;
    end else if (run_q && ge_s) begin
      rem_q   <= rem_q - pow_s;
      digit_q <= digit_q + 4'd1;
    end else begin
      run_q   <= 1'b0;
    end
  end

  assign digit_o = digit_q;
  assign rem_o   = rem_q;
  assign done_o  = run_q & ~ge_s;

endmodule

// File: rtl/uart_axis_scheduler.sv
// Periodically snapshots X/Y/Z and streams "X+ddddd Y+ddddd Z+ddddd\r\n" over valid/ready.
// Define UART_SCHED_OVERRUN_CNT_EN to add the saturating dropped-tick counter output overrun_cnt.
module uart_axis_scheduler
  import uart_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES = 64000000,
  parameter int VALUE_W       = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value_X,
  input  logic [VALUE_W-1:0] value_Y,
  input  logic [VALUE_W-1:0] value_Z,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done
`ifdef UART_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]         overrun_cnt
`endif
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               tick_s;
  state_e             state_q;
  logic [VALUE_W-1:0] snap_x_q;
  logic [VALUE_W-1:0] snap_y_q;
  logic [VALUE_W-1:0] snap_z_q;
  logic [VALUE_W-1:0] rem_q;
  logic [VALUE_W-1:0] cur_val_s;
  logic [VALUE_W-1:0] cur_mag_s;
  logic [VALUE_W-1:0] ext_rem_s;
  logic [3:0]         ext_digit_s;
  logic               ext_done_s;
  logic [1:0]         axis_q;
  logic [2:0]         dig_q;
  logic               start_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               xfer_s;

  always_comb begin
    tick_s = (cnt_q == CNT_W'(PERIOD_CYCLES - 1));
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Current axis sample and its magnitude; the most negative value maps onto itself.
  always_comb begin
    case (axis_q)
      2'd0:    cur_val_s = snap_x_q;
      2'd1:    cur_val_s = snap_y_q;
      default: cur_val_s = snap_z_q;
    endcase
    if (cur_val_s[VALUE_W-1]) begin
      cur_mag_s = ~cur_val_s + VALUE_W'(1);
    end else begin
      cur_mag_s = cur_val_s;
    end
  end

  assign xfer_s = tx_valid_q & tx_ready;

  dec_digit_extractor #(
    .W(VALUE_W)
  ) u_digit (
    .clk    (clk),
    .reset  (reset),
    .start_i(start_q),
    .mag_i  (rem_q),
    .idx_i  (dig_q),
    .digit_o(ext_digit_s),
    .rem_o  (ext_rem_s),
    .done_o (ext_done_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      snap_x_q     <= {VALUE_W{1'b0}};
      snap_y_q     <= {VALUE_W{1'b0}};
      snap_z_q     <= {VALUE_W{1'b0}};
      rem_q        <= {VALUE_W{1'b0}};
      axis_q       <= 2'd0;
      dig_q        <= 3'd0;
      start_q      <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        // DONE behaves like IDLE so a tick landing right after a frame is not lost.
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (tick_s) begin
            snap_x_q <= value_X;
            snap_y_q <= value_Y;
            snap_z_q <= value_Z;
            axis_q   <= 2'd0;
            busy_q   <= 1'b1;
            state_q  <= ST_SNAP;
          end
        end
        ST_SNAP: begin
          tx_data_q  <= ASCII_X;
          tx_valid_q <= 1'b1;
          state_q    <= ST_TAG;
        end
        ST_TAG: begin
          if (xfer_s) begin
            tx_data_q <= cur_val_s[VALUE_W-1] ? ASCII_MINUS : ASCII_PLUS;
            rem_q     <= cur_mag_s;
            state_q   <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (xfer_s) begin
            tx_valid_q <= 1'b0;
            start_q    <= 1'b1;
            dig_q      <= 3'd0;
            state_q    <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (ext_done_s) begin
            tx_data_q  <= ASCII_ZERO + {4'b0000, ext_digit_s};
            tx_valid_q <= 1'b1;
            rem_q      <= ext_rem_s;
            state_q    <= ST_DIGIT;
          end
        end
        ST_DIGIT: begin
          if (xfer_s) begin
            if (dig_q != 3'(NUM_DIGITS - 1)) begin
              dig_q      <= dig_q + 3'd1;
              tx_valid_q <= 1'b0;
              start_q    <= 1'b1;
              state_q    <= ST_CONV;
            end else if (axis_q != 2'd2) begin
              tx_data_q <= ASCII_SPACE;
              state_q   <= ST_SEP;
            end else begin
              tx_data_q <= ASCII_CR;
              state_q   <= ST_CR;
            end
          end
        end
        ST_SEP: begin
          if (xfer_s) begin
            tx_data_q <= (axis_q == 2'd0) ? ASCII_Y : ASCII_Z;
            axis_q    <= axis_q + 2'd1;
            state_q   <= ST_TAG;
          end
        end
        ST_CR: begin
          if (xfer_s) begin
            tx_data_q <= ASCII_LF;
            state_q   <= ST_LF;
          end
        end
        ST_LF: begin
          if (xfer_s) begin
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q <= 8'd0;
    end else if (tick_s && busy_q && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_cnt = overrun_q;
`endif

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_axis_scheduler.sv
// Scoreboard bench for uart_axis_scheduler: expected frame bytes are queued when
// a scenario is set up and compared as the DUT hands bytes over.
module tb_uart_axis_scheduler;

  localparam int TB_PERIOD = 200;

  logic        clk;
  logic        reset;
  logic [14:0] value_X;
  logic [14:0] value_Y;
  logic [14:0] value_Z;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
`ifdef UART_SCHED_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          xfer_cnt = 0;
  int          frame_bytes = 0;
  int          busy_rise_cyc = -1;
  int          rdy_mode = 0;
  int          rdy_phase = 0;
  logic        stall_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic [7:0]  hold_data = 8'h00;
  logic [7:0]  exp_q[$];

  uart_axis_scheduler #(
    .PERIOD_CYCLES(TB_PERIOD),
    .VALUE_W      (15)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .value_X   (value_X),
    .value_Y   (value_Y),
    .value_Z   (value_Z),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef UART_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [14:0] x, input logic [14:0] y, input logic [14:0] z);
    logic [14:0] v[3];
    int          val;
    int          mag;
    int          p;
    v = '{x, y, z};
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(8'h58 + 8'(a));
      val = int'($signed(v[a]));
      mag = (val < 0) ? -val : val;
      exp_q.push_back((val < 0) ? 8'h2D : 8'h2B);
      p = 10000;
      for (int k = 0; k < 5; k++) begin
        exp_q.push_back(8'h30 + 8'((mag / p) % 10));
        p = p / 10;
      end
      if (a < 2) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Drive tx_ready for the coming edge, then score the handshake it will complete.
  always @(negedge clk) begin
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: begin
        tx_ready  = (rdy_phase == 2);
        rdy_phase = (rdy_phase + 1) % 3;
      end
      default: tx_ready = 1'b0;
    endcase
    if (reset) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(hold_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        xfer_cnt++;
        frame_bytes++;
      end
      if (done_prev) chk("done_width", 32'(frame_done), 32'd0);
      if (frame_done) begin
        done_cnt++;
        chk("done_len", 32'(frame_bytes), 32'd25);
        chk("done_busy", 32'(busy), 32'd0);
        frame_bytes = 0;
      end
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      stall_prev = tx_valid && !tx_ready;
      hold_data  = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
    done_prev = frame_done;
    busy_prev = busy;
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
`ifdef UART_SCHED_OVERRUN_CNT_EN
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
`endif
    exp_q.delete();
    done_cnt      = 0;
    xfer_cnt      = 0;
    frame_bytes   = 0;
    busy_rise_cyc = -1;
    reset         = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    #2 chk(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_xfer(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && xfer_cnt < target; i++) @(posedge clk);
    #2 chk(tag, 32'(xfer_cnt >= target), 32'd1);
  endtask

  initial begin
    reset    = 1'b0;
    tx_ready = 1'b1;
    value_X  = 15'd0;
    value_Y  = 15'd0;
    value_Z  = 15'd0;
    repeat (3) @(posedge clk);

    // Positive values, always ready
    value_X = 15'd102; value_Y = 15'd70; value_Z = 15'd0; rdy_mode = 0;
    do_reset();
    push_frame(15'd102, 15'd70, 15'd0);
    wait_done("s1_done", 1, 600);
    chk("s1_start", 32'(busy_rise_cyc), 32'(TB_PERIOD));
    chk("s1_drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2 chk("s1_busy_after", 32'(busy), 32'd0);
    chk("s1_valid_after", 32'(tx_valid), 32'd0);

    // Negative values and the most negative value
    value_X = 15'h7FFF; value_Y = 15'h4000; value_Z = 15'h3FFF;
    do_reset();
    push_frame(15'h7FFF, 15'h4000, 15'h3FFF);
    wait_done("s2_done", 1, 600);
    chk("s2_drain", 32'(exp_q.size()), 32'd0);

    // Ready one cycle in three
    value_X = 15'd102; value_Y = 15'd70; value_Z = 15'd0; rdy_mode = 1;
    do_reset();
    push_frame(15'd102, 15'd70, 15'd0);
    wait_done("s3_done", 1, 800);
    chk("s3_drain", 32'(exp_q.size()), 32'd0);

    // Long stall: ticks during the frame are dropped
    rdy_mode = 2;
    do_reset();
    push_frame(15'd102, 15'd70, 15'd0);
    push_frame(15'd102, 15'd70, 15'd0);
    for (int i = 0; i < 2000 && cyc < 6 * TB_PERIOD; i++) @(posedge clk);
    #2 rdy_mode = 0;
    wait_done("s4_done1", 1, 400);
`ifdef UART_SCHED_OVERRUN_CNT_EN
    chk("s4_overrun", 32'(overrun_cnt), 32'd5);
`endif
    wait_done("s4_done2", 2, 600);
    chk("s4_restart", 32'(busy_rise_cyc), 32'(7 * TB_PERIOD));
    chk("s4_drain", 32'(exp_q.size()), 32'd0);

    // Input change mid-frame only affects the next frame
    value_X = 15'd102;
    do_reset();
    push_frame(15'd102, 15'd70, 15'd0);
    push_frame(15'd70, 15'd70, 15'd0);
    wait_xfer("s5_reach_y", 8, 600);
    value_X = 15'd70;
    wait_done("s5_done", 2, 800);
    chk("s5_second_start", 32'(busy_rise_cyc), 32'(2 * TB_PERIOD));
    chk("s5_drain", 32'(exp_q.size()), 32'd0);

    // One-cycle reset after byte 10 abandons the frame
    value_X = 15'd102;
    do_reset();
    push_frame(15'd102, 15'd70, 15'd0);
    wait_xfer("s6_reach_10", 10, 600);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    chk("s6_valid_low", 32'(tx_valid), 32'd0);
    chk("s6_busy_low", 32'(busy), 32'd0);
    chk("s6_no_done", 32'(done_cnt), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    frame_bytes   = 0;
    busy_rise_cyc = -1;
    push_frame(15'd102, 15'd70, 15'd0);
    wait_done("s6_done", 1, 600);
    chk("s6_start", 32'(busy_rise_cyc), 32'(TB_PERIOD));
    chk("s6_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
